// File: rtl/pool_layer.sv
// Max-pooling stage: reduces each POOL_SIZE consecutive input vectors to their per-channel signed maximum.
// Optional build macro POOL_RELU_EN clamps negative input words to zero before the compare.
module pool_layer #(
    parameter int unsigned N_CHANNELS   = 1,
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned POOL_SIZE    = 2,
    parameter int unsigned INPUT_LENGTH = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    output logic                             pool_ready_o,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [N_CHANNELS*WORD_SIZE-1:0]  data_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [N_CHANNELS*WORD_SIZE-1:0]  data_o
);

    localparam int unsigned DATA_W     = N_CHANNELS * WORD_SIZE;
    localparam int unsigned IN_CNT_W   = $clog2(INPUT_LENGTH + 1);
    localparam int unsigned POOL_CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;

    localparam logic [IN_CNT_W-1:0]   IN_LAST   = IN_CNT_W'(INPUT_LENGTH - 1);
    localparam logic [IN_CNT_W-1:0]   IN_FULL   = IN_CNT_W'(INPUT_LENGTH);
    localparam logic [POOL_CNT_W-1:0] POOL_LAST = POOL_CNT_W'(POOL_SIZE - 1);

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eACCUM = 2'd1,
        eEMIT  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IN_CNT_W-1:0]     in_cnt_q, in_cnt_d;
    logic [POOL_CNT_W-1:0]   pool_cnt_q, pool_cnt_d;
    logic [DATA_W-1:0]       max_q, max_d;
    logic                    ready_q, valid_q, pool_ready_q;
    logic [DATA_W-1:0]       data_cond;
    logic                    hs_in, hs_out;

    // Input word conditioning (ReLU clamp when enabled)
    always_comb begin
        data_cond = data_i;
`ifdef POOL_RELU_EN
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
            if (data_i[c*WORD_SIZE + WORD_SIZE - 1]) begin
                data_cond[c*WORD_SIZE +: WORD_SIZE] = '0;
            end
        end
`endif
    end

    // Handshakes use registered ready/valid only, so no input-to-output combinational path exists
    assign hs_in  = valid_i && ready_q;
    assign hs_out = valid_q && ready_i;

    always_comb begin
        logic [WORD_SIZE-1:0] cur_w;
        logic [WORD_SIZE-1:0] in_w;
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        pool_cnt_d = pool_cnt_q;
        max_d      = max_q;
        cur_w      = '0;
        in_w       = '0;
        case (state_q)
            eIDLE: begin
                in_cnt_d   = '0;
                pool_cnt_d = '0;
                if (start_i) begin
                    state_d = eACCUM;
                end
            end
            eACCUM: begin
                if (hs_in) begin
                    for (int unsigned c = 0; c < N_CHANNELS; c++) begin
                        cur_w = max_q[c*WORD_SIZE +: WORD_SIZE];
                        in_w  = data_cond[c*WORD_SIZE +: WORD_SIZE];
                        if ((pool_cnt_q == '0) || ($signed(in_w) > $signed(cur_w))) begin
                            max_d[c*WORD_SIZE +: WORD_SIZE] = in_w;
                        end
                    end
                    in_cnt_d = in_cnt_q + IN_CNT_W'(1);
                    if (pool_cnt_q == POOL_LAST) begin
                        pool_cnt_d = '0;
                        state_d    = eEMIT;
                    end else begin
                        pool_cnt_d = pool_cnt_q + POOL_CNT_W'(1);
                        // Tail vector of an incomplete window: consume and drop the partial result
                        if (in_cnt_q == IN_LAST) begin
                            state_d = eIDLE;
                        end
                    end
                end
            end
            eEMIT: begin
                if (hs_out) begin
                    state_d = (in_cnt_q == IN_FULL) ? eIDLE : eACCUM;
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= eIDLE;
            in_cnt_q     <= '0;
            pool_cnt_q   <= '0;
            max_q        <= '0;
            ready_q      <= 1'b0;
            valid_q      <= 1'b0;
            pool_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            pool_cnt_q   <= pool_cnt_d;
            max_q        <= max_d;
            ready_q      <= (state_d == eACCUM);
            valid_q      <= (state_d == eEMIT);
            pool_ready_q <= (state_d == eIDLE);
        end
    end

    assign ready_o      = ready_q;
    assign valid_o      = valid_q;
    assign pool_ready_o = pool_ready_q;
    assign data_o       = max_q;

endmodule

// File: tb/tb_pool_layer.sv
// Scoreboard bench for pool_layer: driver pushes expected pooled vectors, negedge monitor pops and compares.
module tb_pool_layer;

    localparam int unsigned NC = 2;
    localparam int unsigned W  = 16;
    localparam int unsigned P  = 2;
    localparam int unsigned L  = 5;

    typedef logic [NC*W-1:0] vec_t;

    logic clk_i = 1'b0;
    logic reset_n_i, start_i, pool_ready_o, valid_i, ready_o, valid_o, ready_i;
    vec_t data_i, data_o;

    pool_layer #(
        .N_CHANNELS  (NC),
        .WORD_SIZE   (W),
        .POOL_SIZE   (P),
        .INPUT_LENGTH(L)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .start_i     (start_i),
        .pool_ready_o(pool_ready_o),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o)
    );

    always #5 clk_i = ~clk_i;

    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit   start_noise = 0;
    vec_t exp_q[$];
    vec_t frame[L];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] x);
`ifdef POOL_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    function automatic vec_t mk(input int a, input int b);
        return {W'(b), W'(a)};
    endfunction

    function automatic int rv();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 6)) - 3;
        return int'($urandom);
    endfunction

    // Reference: per window, per channel, signed max of the (optionally clamped) words
    task automatic push_expected();
        for (int w = 0; w < int'(L / P); w++) begin
            vec_t e;
            for (int c = 0; c < int'(NC); c++) begin
                logic signed [W-1:0] m, x;
                m = relu(frame[w*P][c*W +: W]);
                for (int k = 1; k < int'(P); k++) begin
                    x = relu(frame[w*P + k][c*W +: W]);
                    if (x > m) m = x;
                end
                e[c*W +: W] = m;
            end
            exp_q.push_back(e);
        end
    endtask

    // Backpressure generator
    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(0, 3) != 0);
            default: ready_i = 1'b0;
        endcase
    end

    // Monitor: every output handshake must match the head of the scoreboard
    always @(negedge clk_i) begin
        if (reset_n_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(data_o), 64'hDEAD);
            end else begin
                check("out_data", 64'(data_o), 64'(exp_q.pop_front()));
                n_out++;
            end
        end
    end

    task automatic start_frame();
        bit seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (pool_ready_o) begin
                seen = 1;
                break;
            end
        end
        check("idle_before_start", 64'(seen), 64'd1);
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_start", 64'(ready_o), 64'd1);
    endtask

    task automatic send_vec(input vec_t v, input int gap);
        bit done = 0;
        repeat (gap) @(posedge clk_i);
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        data_i  = v;
        start_i = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (ready_o) begin
                done = 1;
                break;
            end
        end
        if (!done) check("input_timeout", 64'd0, 64'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        start_i = 1'b0;
        data_i  = vec_t'({$urandom, $urandom});
    endtask

    task automatic stall_check();
        vec_t snap;
        int   prev;
        @(negedge clk_i);
        snap = data_o;
        check("stall_valid_rise", 64'(valid_o), 64'd1);
        repeat (10) begin
            @(negedge clk_i);
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_data", 64'(data_o), 64'(snap));
            check("stall_ready", 64'(ready_o), 64'd0);
        end
        prev = n_out;
        rdy_mode = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("stall_single_hs", 64'(n_out), 64'(prev + 1));
        check("stall_valid_drop", 64'(valid_o), 64'd0);
    endtask

    task automatic run_frame(input bit stall, input bit rand_gap);
        start_frame();
        push_expected();
        for (int i = 0; i < int'(L); i++) begin
            send_vec(frame[i], rand_gap ? int'($urandom_range(0, 2)) : 0);
            if (stall && i == int'(P) - 1) stall_check();
        end
        // Tail vector just consumed: back to idle next cycle, no extra output
        @(negedge clk_i);
        check("pool_ready_after_tail", 64'(pool_ready_o), 64'd1);
        check("no_tail_output", 64'(valid_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0;
        start_i   = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        data_i    = '0;
        repeat (3) @(negedge clk_i);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_pool_ready", 64'(pool_ready_o), 64'd1);
        check("rst_data", 64'(data_o), 64'd0);
        reset_n_i = 1'b1;

        frame = '{mk(3, 1), mk(7, 2), mk(-2, 3), mk(5, 4), mk(11, 5)};
        run_frame(0, 0);
        frame = '{mk(-4, -1), mk(-9, -1), mk(-1, -1), mk(-3, -1), mk(-6, -1)};
        run_frame(0, 0);
        frame = '{mk(1, 1), mk(2, 2), mk(3, 3), mk(4, 4), mk(100, 100)};
        run_frame(0, 1);

        frame = '{mk(5, -8), mk(-3, 6), mk(rv(), rv()), mk(rv(), rv()), mk(rv(), rv())};
        rdy_mode = 2;
        run_frame(1, 0);

        // Abort mid-window with reset, then a clean frame must show no leftovers
        rdy_mode = 0;
        start_frame();
        send_vec(mk(50, 50), 0);
        reset_n_i = 1'b0;
        #1;
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_ready", 64'(ready_o), 64'd0);
        check("abort_pool_ready", 64'(pool_ready_o), 64'd1);
        check("abort_data", 64'(data_o), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        frame = '{mk(9, 2), mk(1, 1), mk(0, 0), mk(0, 0), mk(7, 7)};
        run_frame(0, 0);

        rdy_mode    = 1;
        start_noise = 1;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < int'(L); i++) frame[i] = mk(rv(), rv());
            run_frame(0, 1);
        end
        start_noise = 0;

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk_i);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool_layer.md
# pool_layer

Max-pooling stage sitting directly downstream of the convolutional layer. Consumes that layer's packed per-channel output vectors over a ready/valid handshake, reduces every POOL_SIZE consecutive vectors to their element-wise signed maximum, and hands the pooled vector to the next layer over a ready/valid handshake. One frame (INPUT_LENGTH vectors) is processed per start_i pulse. Any partial window at the end of a frame is consumed and discarded.

## Interface
Parameters:
- N_CHANNELS, 1, number of parallel channels (packed words per vector)
- WORD_SIZE, 16, bits per word, two's-complement
- POOL_SIZE, 2, vectors per pooling window, ≥1
- INPUT_LENGTH, 4, vectors per frame, ≥POOL_SIZE

Ports (one clock; reset is asynchronous and active-low):
- clk_i  input  1  clock, all state on rising edge
- reset_n_i  input  1  asynchronous active-low reset
- start_i  input  1  begin a frame; sampled only in eIDLE
- pool_ready_o  output  1  high in eIDLE
- valid_i  input  1  upstream data valid
- ready_o  output  1  block accepts data this cycle
- data_i  input  N_CHANNELS*WORD_SIZE  channel c in bits [c*WORD_SIZE +: WORD_SIZE]
- valid_o  output  1  pooled vector valid
- ready_i  input  1  downstream accepts
- data_o  output  N_CHANNELS*WORD_SIZE  pooled vector, same packing

## Operation
- States: eIDLE, eACCUM, eEMIT.
- eIDLE: ready_o=0, valid_o=0; in_cnt, pool_cnt cleared; start_i → eACCUM.
- eACCUM: ready_o=1. Handshake in = valid_i && ready_o. On handshake, per channel: pool_cnt==0 → max_r[c]=data_i[c]; else max_r[c]=signed max(max_r[c], data_i[c]); in_cnt++, pool_cnt++ (wraps to 0 at POOL_SIZE).
  - Handshake with pool_cnt==POOL_SIZE-1 → eEMIT.
  - Otherwise handshake with in_cnt==INPUT_LENGTH-1 (tail vector, window incomplete) → eIDLE; partial max_r discarded, nothing emitted.
- eEMIT: ready_o=0, valid_o=1, data_o=max_r. On ready_i: in_cnt==INPUT_LENGTH → eIDLE, else → eACCUM.
- Outputs per frame: floor(INPUT_LENGTH/POOL_SIZE); tail vectors: INPUT_LENGTH mod POOL_SIZE.
- Comparison strictly signed, WORD_SIZE bits, no widening; equal values are indistinguishable.
- start_i outside eIDLE ignored.
- POOL_SIZE==1: every vector passes through (with optional ReLU) unchanged.

## Timing
- Reset (async assert, sync release): state eIDLE, counters 0, max_r 0, valid_o 0, ready_o 0, data_o 0, pool_ready_o 1.
- start_i high in cycle t → ready_o high in t+1.
- Last handshake of a window in cycle t → valid_o high in t+1 with data_o final.
- valid_o/data_o held stable until ready_i; no combinational path ready_i→valid_o or valid_i→ready_o (both decoded from registered state only).
- Throughput: one output every POOL_SIZE+1 cycles minimum; no input accepted while in eEMIT.
- Last output handshake in cycle t (no tail) → pool_ready_o high in t+1.
- Reset mid-frame: immediate return to reset values; partial window lost.

## Configuration
- POOL_RELU_EN defined: each incoming word with sign bit set is replaced by 0 before the compare/load; all outputs ≥0.
- POOL_RELU_EN undefined: raw signed max; negative outputs possible. Control behaviour identical in both builds.

## Test plan
- N_CHANNELS=1, POOL_SIZE=2, INPUT_LENGTH=4, inputs 3,7,-2,5, ready_i=1 → outputs 7 then 5; pool_ready_o high cycle after second output.
- All-negative inputs -4,-9,-1,-3: without POOL_RELU_EN → -4,-1; with POOL_RELU_EN → 0,0.
- INPUT_LENGTH=5, inputs 1,2,3,4,100 → outputs 2,4 only; 100 consumed (ready_o high for it), returns to eIDLE with no third valid_o.
- N_CHANNELS=2, pairs {ch0,ch1} = {5,-8},{-3,6} → data_o {5,6}; channels independent.
- ready_i held low 10 cycles in eEMIT → valid_o stays 1, data_o constant, ready_o stays 0; release → single handshake.
- reset_n_i pulsed low after first input of a window → all outputs at reset values in same cycle; new start_i frame 9,1,0,0 → outputs 9,0 (no leftover from aborted window).
